// File: rtl/float_to_double.sv
`default_nettype none
// ============================================================================
// Module   : float_to_double
// Purpose  : Sequential IEEE-754 binary32 -> binary64 widening converter.
//            Widening is exact, so there is no rounding. The only multi-cycle
//            work is normalising binary32 subnormals, one bit per clock.
//            Every operand class is staged through CHECK and a final write
//            step in NORM. A normal operand therefore completes two edges
//            after acceptance. A subnormal needing s shifts completes 2+s
//            edges after acceptance.
// Ports    : clk                - clock, rising edge
//            rst_n              - asynchronous active-low reset
//            i_start            - request, sampled only in IDLE or DONE
//            i_float[31:0]      - binary32 operand, latched when accepted
//            o_double[63:0]     - binary64 result, valid while o_done=1
//            o_done             - result valid; cleared by next accept/reset
//            o_busy             - conversion in progress (CHECK or NORM)
//            o_nan_exception    - operand was a signalling NaN
//            o_subnormal_input  - operand was a binary32 subnormal
// Revision : 1.0 - initial release
// ============================================================================
module float_to_double #(
   parameter int EXP_BIAS_64 = 1023,
   parameter int EXP_BIAS_32 = 127
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        i_start,
   input  logic [31:0] i_float,
   output logic [63:0] o_double,
   output logic        o_done,
   output logic        o_busy,
   output logic        o_nan_exception,
   output logic        o_subnormal_input
);

   // Exponent offset between the two formats. A subnormal starts one above
   // it, because its implicit exponent is 1-127 rather than 0-127.
   localparam logic [10:0] c_REBIAS  = 11'(EXP_BIAS_64 - EXP_BIAS_32);
   localparam logic [10:0] c_SUB_EXP = c_REBIAS + 11'd1;

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_CHECK = 2'd1,
      S_NORM  = 2'd2,
      S_DONE  = 2'd3
   } state_t;

   state_t      r_state;
   state_t      w_next_state;

   logic        r_sign;
   logic [7:0]  r_exp8;
   logic [22:0] r_frac;
   logic [23:0] r_mant;
   logic [10:0] r_xexp;
   logic [63:0] r_double;
   logic        r_done;
   logic        r_nan;
   logic        r_sub;

   logic        w_accept;
   logic        w_exp_zero;
   logic        w_exp_max;
   logic        w_frac_zero;
   logic        w_is_sub;
   logic        w_is_snan;
   logic [10:0] w_norm_exp;
   logic [23:0] w_ld_mant;
   logic [10:0] w_ld_xexp;

   assign w_accept    = i_start && ((r_state == S_IDLE) || (r_state == S_DONE));

   // Classification of the latched operand.
   assign w_exp_zero  = (r_exp8 == 8'h00);
   assign w_exp_max   = (r_exp8 == 8'hFF);
   assign w_frac_zero = (r_frac == 23'h000000);
   assign w_is_sub    = w_exp_zero && !w_frac_zero;
   assign w_is_snan   = w_exp_max && !w_frac_zero && !r_frac[22];
   assign w_norm_exp  = {3'b000, r_exp8} + c_REBIAS;

   // Mantissa/exponent pair loaded in CHECK. Non-subnormal classes get a
   // leading one so the first NORM step writes them straight out; a
   // subnormal gets its raw fraction and is shifted until bit 23 is set.
   always_comb begin
      w_ld_mant = {1'b1, r_frac};
      w_ld_xexp = w_norm_exp;
      if (w_exp_max) begin
         // Infinity has a zero fraction; any NaN gets its quiet bit forced,
         // which leaves a qNaN untouched and quiets an sNaN.
         w_ld_xexp = 11'h7FF;
         w_ld_mant = {1'b1, !w_frac_zero, r_frac[21:0]};
      end else if (w_exp_zero) begin
         if (w_frac_zero) begin
            w_ld_xexp = 11'h000;
            w_ld_mant = {1'b1, 23'h000000};
         end else begin
            w_ld_xexp = c_SUB_EXP;
            w_ld_mant = {1'b0, r_frac};
         end
      end
   end

   // State register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_next_state;
      end
   end

   // Next-state logic.
   always_comb begin
      w_next_state = r_state;
      case (r_state)
         S_IDLE:  if (i_start)    w_next_state = S_CHECK;
         S_CHECK:                 w_next_state = S_NORM;
         S_NORM:  if (r_mant[23]) w_next_state = S_DONE;
         S_DONE:  if (i_start)    w_next_state = S_CHECK;
         default:                 w_next_state = S_IDLE;
      endcase
   end

   // Datapath and output registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_sign   <= 1'b0;
         r_exp8   <= 8'h00;
         r_frac   <= 23'h000000;
         r_mant   <= 24'h000000;
         r_xexp   <= 11'h000;
         r_double <= 64'h0;
         r_done   <= 1'b0;
         r_nan    <= 1'b0;
         r_sub    <= 1'b0;
      end else begin
         if (w_accept) begin
            r_sign <= i_float[31];
            r_exp8 <= i_float[30:23];
            r_frac <= i_float[22:0];
            r_done <= 1'b0;
            r_nan  <= 1'b0;
            r_sub  <= 1'b0;
         end
         if (r_state == S_CHECK) begin
            r_mant <= w_ld_mant;
            r_xexp <= w_ld_xexp;
            r_nan  <= w_is_snan;
            r_sub  <= w_is_sub;
         end
         if (r_state == S_NORM) begin
            if (r_mant[23]) begin
               // The leading one is implicit in binary64; drop it.
               r_double <= {r_sign, r_xexp, r_mant[22:0], 29'h0};
               r_done   <= 1'b1;
            end else begin
               // At most 23 shifts, so the exponent never drops below 874.
               r_mant <= {r_mant[22:0], 1'b0};
               r_xexp <= r_xexp - 11'd1;
            end
         end
      end
   end

   assign o_double          = r_double;
   assign o_done            = r_done;
   assign o_busy            = (r_state == S_CHECK) || (r_state == S_NORM);
   assign o_nan_exception   = r_nan;
   assign o_subnormal_input = r_sub;

endmodule
`default_nettype wire
